// File: rtl/sbox_word_seq.sv
// sbox_word_seq: sequenced SubWord unit.
// Accepts one word per transaction and substitutes every byte through the
// S-box chosen by in_op: AES forward, AES inverse, SM4, or bypass.
// Default build: one shared S-box slice, one byte per cycle.
// Define SBOX_WORD_PARALLEL_EN to build NBYTES parallel lanes instead.
// With that build every word is finished in a single BUSY cycle.
module sbox_word_seq #(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES,
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_word,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_word,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_AES_FWD = 2'b00,
    OP_AES_INV = 2'b01,
    OP_SM4     = 2'b10,
    OP_BYPASS  = 2'b11
  } op_e;

  // NOTE: the S-box tables are constants, so they become combinational ROM
  // logic. They have no storage and therefore need no reset.
  localparam logic [7:0] AES_FWD [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] AES_INV [0:255] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  localparam logic [7:0] SM4_SBOX [0:255] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  // One S-box slice. All three circuits see the same byte, and a 4:1 mux
  // picks the result. Bypass returns the byte unchanged.
  function automatic logic [7:0] sub_byte(input op_e op, input logic [7:0] b);
    logic [7:0] fwd;
    logic [7:0] inv;
    logic [7:0] sm4;
    fwd = AES_FWD[b];
    inv = AES_INV[b];
    sm4 = SM4_SBOX[b];
    case (op)
      OP_AES_FWD: sub_byte = fwd;
      OP_AES_INV: sub_byte = inv;
      OP_SM4:     sub_byte = sm4;
      default:    sub_byte = b;
    endcase
  endfunction

  state_e         state_q, state_d;
  op_e            op_q;
  logic [W-1:0]   data_q;
  logic [W-1:0]   data_sub;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_next;
  logic           last_byte;
  logic           accept;

`ifdef SBOX_WORD_PARALLEL_EN
  // Parallel lanes: substitute every byte of the word in a single cycle.
  always_comb begin
    data_sub = data_q;
    for (int i = 0; i < NBYTES; i++) begin
      data_sub[8*i +: 8] = sub_byte(op_q, data_q[8*i +: 8]);
    end
  end

  assign last_byte = 1'b1;
  assign cnt_next  = '0;
`else
  logic [7:0] sel_byte;
  logic [7:0] sub_res;

  // Serial slice: pick the byte at cnt_q, substitute it, and write it back
  // in place. The other bytes pass through unchanged.
  // NOTE: every variable written here gets a default first. Any path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (cnt_q == CW'(i)) sel_byte = data_q[8*i +: 8];
    end
    sub_res  = sub_byte(op_q, sel_byte);
    data_sub = data_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (cnt_q == CW'(i)) data_sub[8*i +: 8] = sub_res;
    end
  end

  assign last_byte = (cnt_q == CW'(NBYTES - 1));
  assign cnt_next  = last_byte ? '0 : cnt_q + CW'(1);
`endif

  assign accept = in_valid & in_ready;

  // Next-state logic and handshake outputs. in_ready depends on out_ready
  // only, never on in_valid.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (last_byte) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = in_valid ? S_BUSY : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, data, op and counter registers. The word and the op are sampled
  // only on accept. The data register is reset because out_word must read
  // zero out of reset.
  // NOTE: sequential state uses non-blocking assignments. This lets every
  // register sample pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      op_q    <= OP_AES_FWD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= in_word;
        op_q   <= op_e'(in_op);
        cnt_q  <= '0;
      end else if (state_q == S_BUSY) begin
        data_q <= data_sub;
        cnt_q  <= cnt_next;
      end
    end
  end

  assign out_word = data_q;

endmodule

// File: tb/tb_sbox_word_seq.sv
// Self-checking bench for sbox_word_seq (NBYTES = 4).
// The reference model derives the AES S-box from GF(2^8) inversion plus
// the affine map, and derives AES-inverse by inverting that table.
// SM4 uses its published table.
module tb_sbox_word_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;
`ifdef SBOX_WORD_PARALLEL_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = NBYTES;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_word;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_word;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] aes_fwd_m [256];
  logic [7:0] aes_inv_m [256];
  logic [7:0] sm4_m [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  sbox_word_seq #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [W-1:0] model_word(input logic [W-1:0] w, input logic [1:0] op);
    logic [W-1:0] r;
    logic [7:0]   b;
    r = w;
    for (int i = 0; i < NBYTES; i++) begin
      b = w[8*i +: 8];
      case (op)
        2'b00:   r[8*i +: 8] = aes_fwd_m[b];
        2'b01:   r[8*i +: 8] = aes_inv_m[b];
        2'b10:   r[8*i +: 8] = sm4_m[b];
        default: r[8*i +: 8] = b;
      endcase
    end
    return r;
  endfunction

  // Offer a word. Returns #1 after the accept edge, in the first BUSY cycle.
  task automatic send(input logic [W-1:0] word, input logic [1:0] op,
                      input logic [W-1:0] scr_word, input logic [1:0] scr_op,
                      input string tag);
    in_valid = 1'b1;
    in_word  = word;
    in_op    = op;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_word  = scr_word;
    in_op    = scr_op;
    check({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  // Bounded wait for out_valid, then check latency and value.
  task automatic await_result(input logic [W-1:0] exp, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(EXP_LAT));
    check({tag, "_word"}, 64'(out_word), 64'(exp));
  endtask

  // Hold backpressure for `stall` cycles, then complete the output handshake.
  task automatic drain(input logic [W-1:0] exp, input int stall, input string tag);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_word"}, 64'(out_word), 64'(exp));
      check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check({tag, "_ready_done"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] w;
    logic [1:0]   op;
    logic [W-1:0] exp;
    logic [7:0]   inv;
    logic [7:0]   xb;
    logic [7:0]   yb;

    // Build the AES tables from field arithmetic.
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = 8'(y);
        if (xb != 8'h00 && gmul(xb, yb) == 8'h01) inv = yb;
      end
      aes_fwd_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                     rotl8(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) aes_inv_m[aes_fwd_m[x]] = 8'(x);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    in_op     = 2'b00;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_word", 64'(out_word), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer vectors. Scrambling inputs during BUSY must have no effect.
    send(32'h53020100, 2'b00, 32'hFFFFFFFF, 2'b10, "kat_fwd");
    await_result(32'hED777C63, "kat_fwd");
    drain(32'hED777C63, 0, "kat_fwd");
    send(32'hED777C63, 2'b01, 32'h0, 2'b00, "kat_inv");
    await_result(32'h53020100, "kat_inv");
    drain(32'h53020100, 1, "kat_inv");
    send(32'h03020100, 2'b10, 32'h12345678, 2'b11, "kat_sm4");
    await_result(32'hFEE990D6, "kat_sm4");
    drain(32'hFEE990D6, 0, "kat_sm4");
    send(32'hDEADBEEF, 2'b11, 32'h0, 2'b00, "kat_byp");
    await_result(32'hDEADBEEF, "kat_byp");
    drain(32'hDEADBEEF, 0, "kat_byp");

    // Ten cycles of backpressure, then output and input handshakes on one edge.
    send(32'h53020100, 2'b00, 32'hA5A5A5A5, 2'b01, "bp");
    await_result(32'hED777C63, "bp");
    for (int s = 0; s < 10; s++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_word", 64'(out_word), 64'h00000000ED777C63);
      check("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b1;
    in_word   = 32'h03020100;
    in_op     = 2'b10;
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_out_valid", 64'(out_valid), 64'd0);
    await_result(32'hFEE990D6, "b2b");
    drain(32'hFEE990D6, 0, "b2b");

    // Assert reset on the second BUSY cycle; the in-flight word is dropped.
    send(32'h53020100, 2'b00, 32'h0, 2'b00, "rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_out_word", 64'(out_word), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h00000000, 2'b00, 32'h0, 2'b00, "post_rst");
    await_result(32'h63636363, "post_rst");
    drain(32'h63636363, 0, "post_rst");

    // Random words and ops against the model, with random backpressure.
    for (int t = 0; t < 60; t++) begin
      w   = W'($urandom);
      op  = 2'($urandom_range(0, 3));
      exp = model_word(w, op);
      send(w, op, W'($urandom), 2'($urandom), "rnd");
      await_result(exp, "rnd");
      drain(exp, int'($urandom_range(0, 3)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
